// File: rtl/limn2600_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : limn2600_bus_pkg
// Description : Shared types for the Limn2600 SRAM bus master: FSM state and
//               grant encodings, default data width.
// Revision    : 1.0  initial release
// ============================================================================
package limn2600_bus_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RELEASE = 2'd2
    } bus_state_e;

    // Values double as bit indices into the arbiter's {d, if} request vector
    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } bus_gnt_e;

endpackage
`default_nettype wire

// File: rtl/limn2600_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : limn2600_rr_arbiter
// Description : 2-way round-robin arbiter; on a tie the port not served last
//               wins. Data port (bit 1) is favoured out of reset.
// Revision    : 1.0  initial release
// ============================================================================
module limn2600_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic prio_d_q;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = prio_d_q ? 2'b10 : 2'b01;
        end
    end

    // After serving fetch, data wins the next tie, and vice versa
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_d_q <= 1'b1;
        end else if (advance && (gnt != 2'b00)) begin
            prio_d_q <= gnt[0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/limn2600_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : limn2600_bus_master
// Description : Drives the Limn2600 SRAM port for fetch and load/store clients
//               with round-robin sharing and lagged-ready handshaking.
//               Optional access timeout: LIMN2600_BUS_TIMEOUT_EN.
// Revision    : 1.0  initial release
// ============================================================================
module limn2600_bus_master
    import limn2600_bus_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [31:0]           if_addr,
    output logic                  if_ack,
    output logic [DATA_WIDTH-1:0] if_data,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [31:0]           d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ack,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  err,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_rdy
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    bus_state_e            state_q;
    bus_gnt_e              gnt_q;
    logic [1:0]            arb_req;
    logic [1:0]            arb_gnt;
    logic                  arb_adv;
    logic                  tmo_hit;
    logic                  done;
    logic [DATA_WIDTH-1:0] cap_data;

    assign arb_req  = {d_req, if_req};
    assign arb_adv  = (state_q == IDLE) && (arb_req != 2'b00);
    assign done     = (state_q == ACCESS) && (mem_rdy || tmo_hit);
    assign cap_data = tmo_hit ? '0 : mem_rdata;

    limn2600_rr_arbiter u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (arb_req),
        .advance (arb_adv),
        .gnt     (arb_gnt)
    );

`ifdef LIMN2600_BUS_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TMO_W-1:0] tmo_q;
    logic             err_q;

    // Abort fires on the last of TIMEOUT_CYCLES ready-less ACCESS cycles
    assign tmo_hit = (state_q == ACCESS) && !mem_rdy && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign err     = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= tmo_hit;
            if (state_q != ACCESS) begin
                tmo_q <= '0;
            end else if (!mem_rdy) begin
                tmo_q <= tmo_q + 1'b1;
            end
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= GNT_D;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_data   <= '0;
            d_rdata   <= '0;
        end else begin
            if_ack <= 1'b0;
            d_ack  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (arb_gnt != 2'b00) begin
                        gnt_q     <= arb_gnt[1] ? GNT_D : GNT_IF;
                        mem_addr  <= arb_gnt[1] ? d_addr : if_addr;
                        mem_we    <= arb_gnt[1] & d_we;
                        mem_wdata <= d_wdata;
                        mem_cs    <= 1'b1;
                        state_q   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (done) begin
                        mem_cs  <= 1'b0;
                        mem_we  <= 1'b0;
                        state_q <= RELEASE;
                        if (gnt_q == GNT_IF) begin
                            if_ack  <= 1'b1;
                            if_data <= cap_data;
                        end else begin
                            d_ack <= 1'b1;
                            if (!mem_we) begin
                                d_rdata <= cap_data;
                            end
                        end
                    end
                end
                // mem_rdy lags chip select by a cycle; wait it out before re-arming
                RELEASE: begin
                    if (!mem_rdy) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_limn2600_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_limn2600_bus_master
// Description : Self-checking bench for limn2600_bus_master with a registered
//               SRAM model (ready lags chip select by one cycle).
// Revision    : 1.0  initial release
// ============================================================================
module tb_limn2600_bus_master;

    localparam int DW = 32;
    localparam logic [31:0] ROM0    = 32'h0BAD_F00D;
    localparam logic [31:0] W10     = 32'hDEAD_BEEF;
    localparam logic [31:0] W40     = 32'hCAFE_F00D;
    localparam logic [31:0] W44     = 32'h600D_CAFE;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, d_req, d_we;
    logic [31:0]   if_addr, d_addr;
    logic [DW-1:0] d_wdata;
    logic          if_ack, d_ack, err;
    logic [DW-1:0] if_data, d_rdata;
    logic          mem_cs, mem_we;
    logic [31:0]   mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_rdy;
    logic          sram_dead;

    int checks   = 0;
    int failures = 0;

    limn2600_bus_master #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_data   (if_data),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .err       (err),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rdy   (mem_rdy)
    );

    always #5 clk = ~clk;

    // SRAM model: word-addressed by bits [9:2]; 0xFFFE0000 aliases word 0 (ROM word 0)
    logic [31:0] sram [0:255];
    always @(posedge clk) begin
        mem_rdy <= mem_cs & ~sram_dead;
        if (rst) begin
            sram[0]  <= ROM0;
            sram[4]  <= W10;
            sram[16] <= W40;
            sram[17] <= W44;
        end else if (mem_cs) begin
            if (mem_we) sram[mem_addr[9:2]] <= mem_wdata;
            mem_rdata <= sram[mem_addr[9:2]];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic d_xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output int cs_cyc, output int we_cyc,
                          output logic [31:0] addr_seen, output int stray, output logic err_at_ack);
        lat = -1; cs_cyc = 0; we_cyc = 0; addr_seen = '0; stray = 0; err_at_ack = 1'b0;
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mem_cs) begin cs_cyc++; addr_seen = mem_addr; end
            if (mem_we) we_cyc++;
            if (if_ack) stray++;
            if (d_ack) begin lat = c; err_at_ack = err; break; end
        end
        d_req = 1'b0; d_we = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        vecs [6];
    int          lat, cs_cyc, we_cyc, stray, n_acks, we_hi, both, cs_rise, f_lat, glitch;
    logic [31:0] addr_seen;
    logic        err_at_ack, prev_rdy, rdy_before;
    int          ack_t [4];
    int          ack_p [4];
    logic [31:0] ack_d [4];

    initial begin
        vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,         W10};
        vecs[1] = '{1'b1, 32'h0000_0020, 32'h1234_5678, W10};
        vecs[2] = '{1'b0, 32'h0000_0020, 32'h0,         32'h1234_5678};
        vecs[3] = '{1'b1, 32'h0000_0024, 32'hA5A5_5A5A, 32'h1234_5678};
        vecs[4] = '{1'b0, 32'h0000_0024, 32'h0,         32'hA5A5_5A5A};
        vecs[5] = '{1'b0, 32'h0000_0026, 32'h0,         32'hA5A5_5A5A};

        rst = 1'b1; sram_dead = 1'b0;
        if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_mem_cs", mem_cs, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_acks_err", {if_ack, d_ack, err}, 0);
        chk("rst_if_data", if_data, 0);
        chk("rst_d_rdata", d_rdata, 0);
        rst = 1'b0;
        @(negedge clk);

        // Contention straight out of reset: data port must win first
        for (int k = 0; k < 4; k++) begin ack_t[k] = -1; ack_p[k] = -1; ack_d[k] = '0; end
        if_req = 1'b1; if_addr = 32'hFFFE_0000; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        n_acks = 0; we_hi = 0; both = 0;
        for (int c = 1; c <= 40 && n_acks < 4; c++) begin
            @(negedge clk);
            if (mem_we) we_hi++;
            if (if_ack && d_ack) both++;
            if (if_ack || d_ack) begin
                ack_t[n_acks] = c;
                ack_p[n_acks] = d_ack ? 1 : 0;
                ack_d[n_acks] = d_ack ? d_rdata : if_data;
                n_acks++;
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        chk("cont_nacks", n_acks, 4);
        chk("cont_both_acks", both, 0);
        chk("cont_we_low", we_hi, 0);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("cont_port%0d", k), ack_p[k], (k % 2 == 0) ? 1 : 0);
            chk($sformatf("cont_time%0d", k), ack_t[k], 3 + 5 * k);
            chk($sformatf("cont_data%0d", k), ack_d[k], (k % 2 == 0) ? W40 : ROM0);
        end
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            d_xact(vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, cs_cyc, we_cyc, addr_seen, stray, err_at_ack);
            chk($sformatf("v%0d_latency", i), lat, 3);
            chk($sformatf("v%0d_rdata", i), d_rdata, vecs[i].exp_rdata);
            chk($sformatf("v%0d_cs_cycles", i), cs_cyc, 2);
            chk($sformatf("v%0d_we_cycles", i), we_cyc, vecs[i].we ? 2 : 0);
            chk($sformatf("v%0d_addr", i), addr_seen, vecs[i].addr);
            chk($sformatf("v%0d_no_if_ack_err", i), {stray[7:0], err_at_ack}, 0);
            repeat (2) @(negedge clk);
        end

        // Stale ready: new fetch raised while mem_rdy is still high in RELEASE
        d_xact(1'b0, 32'h40, 32'h0, lat, cs_cyc, we_cyc, addr_seen, stray, err_at_ack);
        chk("stale_first_lat", lat, 3);
        chk("stale_rdy_high", mem_rdy, 1);
        if_req = 1'b1; if_addr = 32'h44;
        prev_rdy = mem_rdy; cs_rise = -1; rdy_before = 1'b1; f_lat = -1; glitch = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (mem_cs && cs_rise < 0) begin cs_rise = c; rdy_before = prev_rdy; end
            prev_rdy = mem_rdy;
            if (d_ack) glitch++;
            if (if_ack) begin f_lat = c; break; end
        end
        if_req = 1'b0;
        chk("stale_cs_rise", cs_rise, 3);
        chk("stale_rdy_low_before_cs", rdy_before, 0);
        chk("stale_fetch_lat", f_lat, 5);
        chk("stale_no_d_ack", glitch, 0);
        chk("stale_if_data", if_data, W44);
        repeat (2) @(negedge clk);

        // Reset during ACCESS with the request held
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; d_wdata = 32'h5555_AAAA;
        @(negedge clk);
        chk("rmid_cs_before", mem_cs, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rmid_mem_cs", mem_cs, 0);
        chk("rmid_acks_err", {if_ack, d_ack, err}, 0);
        chk("rmid_mem_bus", {mem_we, mem_addr, mem_wdata}, 0);
        chk("rmid_d_rdata", d_rdata, 0);
        chk("rmid_if_data", if_data, 0);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (d_ack) begin lat = c; break; end
        end
        d_req = 1'b0;
        chk("rmid_reserved", lat > 0, 1);
        chk("rmid_rdata", d_rdata, W10);
        repeat (2) @(negedge clk);

        // SRAM never answers
        sram_dead = 1'b1;
`ifdef LIMN2600_BUS_TIMEOUT_EN
        d_xact(1'b0, 32'h10, 32'h0, lat, cs_cyc, we_cyc, addr_seen, stray, err_at_ack);
        chk("tmo_latency", lat, 9);
        chk("tmo_err", err_at_ack, 1);
        chk("tmo_rdata_zero", d_rdata, 0);
        chk("tmo_cs_cycles", cs_cyc, 8);
        @(negedge clk);
        chk("tmo_err_pulse", err, 0);
        repeat (2) @(negedge clk);
        sram_dead = 1'b0;
`else
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
        stray = 0;
        for (int c = 1; c <= 1000; c++) begin
            @(negedge clk);
            if (d_ack || if_ack || err) stray++;
        end
        chk("notmo_no_ack", stray, 0);
        chk("notmo_cs_held", mem_cs, 1);
        d_req = 1'b0; rst = 1'b1; sram_dead = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`endif
        d_xact(1'b0, 32'h10, 32'h0, lat, cs_cyc, we_cyc, addr_seen, stray, err_at_ack);
        chk("recover_latency", lat, 3);
        chk("recover_rdata", d_rdata, W10);
        chk("recover_err", err_at_ack, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/limn2600_bus_master.md
# limn2600_bus_master

Bus initiator that drives the Limn2600 on-chip SRAM port (chip select, write enable, address, write data; returns read data and ready) on behalf of the CPU. Two client ports share the one memory port under round-robin arbitration: instruction fetch (read-only) and load/store data (read/write). The block sits between the core's fetch and LSU stages and the SRAM. It also handles the SRAM's sticky, one-cycle-lagged ready.

## Interface
- `DATA_WIDTH`, 32: data bus width.
- `TIMEOUT_CYCLES`, 255: cycles in ACCESS without ready before abort; used only when the timeout feature is compiled in.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `if_req`  in  1  fetch request, held until `if_ack`.
- `if_addr`  in  32  fetch byte address.
- `if_ack`  out  1  one-cycle completion pulse.
- `if_data`  out  DATA_WIDTH  fetch data; valid in the `if_ack` cycle, held until the next fetch ack.
- `d_req`  in  1  data request, held until `d_ack`.
- `d_we`  in  1  1 = write.
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  DATA_WIDTH  store data.
- `d_ack`  out  1  one-cycle completion pulse.
- `d_rdata`  out  DATA_WIDTH  load data; valid in the `d_ack` cycle, held until the next data read ack.
- `err`  out  1  pulses with ack on a timed-out access.
- `mem_cs`  out  1  SRAM chip select.
- `mem_we`  out  1  SRAM write enable.
- `mem_addr`  out  32  SRAM address.
- `mem_wdata`  out  DATA_WIDTH  to SRAM data input.
- `mem_rdata`  in  DATA_WIDTH  from SRAM data output.
- `mem_rdy`  in  1  SRAM ready. It is registered: it rises the cycle after `mem_cs` is first sampled high and falls the cycle after `mem_cs` is first sampled low.

## Operation
- FSM states: IDLE, ACCESS, RELEASE.
- **IDLE:** `mem_cs`=0. If any request is pending:
  - latch the grant, `mem_addr`, `mem_we` (fetch grant forces 0) and `mem_wdata`;
  - set `mem_cs`=1;
  - go to ACCESS.
- **IDLE arbitration:** with both requests pending, grant the port not served last. The pointer flips on each grant.
- **ACCESS:** hold all `mem_*` outputs stable.
  - On `mem_rdy`=1: capture `mem_rdata` into the granted port's data register (reads only), pulse that port's ack, set `mem_cs`=0, go to RELEASE.
- **RELEASE:** `mem_cs`=0. Wait until `mem_rdy`=0, then go to IDLE.
  - A stale high `mem_rdy` is never treated as completion.
- **Writes:** ack carries no data; `d_rdata` is unchanged.
- **Addresses:** passed through unmodified. No alignment check; the SRAM ignores bits [1:0].
- **Request still high at IDLE:** if a client keeps `req` high after its ack and it is still high when the FSM re-enters IDLE, that is a new request.
- **Reset mid-operation:** the FSM returns to IDLE next cycle and no ack is issued for the aborted access. A client still holding `req` is re-served after reset.
- **Reset values:**
  - `mem_cs`, `mem_we`, `mem_addr`, `mem_wdata` = 0;
  - `if_ack`, `d_ack`, `err` = 0;
  - `if_data`, `d_rdata` = 0;
  - state = IDLE;
  - round-robin pointer favours the data port first.

## Timing
- Request sampled in IDLE at cycle N.
  - N+1: `mem_cs` high.
  - N+2: `mem_rdy` high, data captured.
  - N+3: ack pulse, `mem_cs` low, state RELEASE.
  - N+4: `mem_rdy` low.
  - N+5: IDLE.
- Latency from request sampled to ack: 3 cycles.
- Throughput: one access per 5 cycles.
- Ack and `err` are single-cycle pulses, never asserted on both ports in the same cycle.

## Configuration
- Macro: `LIMN2600_BUS_TIMEOUT_EN`.
- **Defined:** an 8+ bit counter clears on entering ACCESS and increments each ACCESS cycle without ready. When it reaches `TIMEOUT_CYCLES`:
  - `mem_cs` drops;
  - the granted port's ack pulses with `err`=1;
  - read data is forced to 0;
  - the FSM goes to RELEASE.
- **Undefined:** ACCESS waits indefinitely; `err` is tied to 0. The port list is identical in both builds.

## Structure
- Shared package `limn2600_bus_pkg` holds:
  - FSM state encoding (IDLE=0, ACCESS=1, RELEASE=2);
  - grant encoding (GNT_IF, GNT_D);
  - default `DATA_WIDTH`.
- One sub-module: `limn2600_rr_arbiter`, a 2-way round-robin arbiter with `req[1:0]`, `advance` in, and one-hot `gnt` out.

## Test plan
- **Single read:** SRAM word 0x10 preloaded 0xDEADBEEF; `d_req` read, `d_addr`=0x10 -> `d_ack` 3 cycles later, `d_rdata`=0xDEADBEEF; `mem_cs` high exactly 2 cycles.
- **Write then read:** write 0x12345678 to 0x20, then read 0x20 -> second ack returns 0x12345678; `mem_we` high only during the write's ACCESS.
- **Contention:** `if_req` (0xFFFE0000) and `d_req` (0x40) raised together and held -> grants alternate D, IF, D, IF; each ack 5 cycles apart; `if_data` equals ROM word 0.
- **Stale ready:** after an access, raise a new request while `mem_rdy` is still 1 in RELEASE -> no early ack; the new `mem_cs` rises only after `mem_rdy` is observed 0.
- **Reset mid-access:** assert `rst` for one cycle during ACCESS -> next cycle `mem_cs`=0, no ack, all outputs at reset values; the held request completes normally afterwards.
- **Timeout (macro defined, `TIMEOUT_CYCLES`=8):** `mem_rdy` tied 0 -> ack with `err`=1 after 8 ACCESS cycles, `d_rdata`=0. Without the macro, no ack within 1000 cycles.
